// File: rtl/cpu_datapath.sv
// cpu_datapath: program counter, instruction register, 16x8 register file,
// RF write-source mux and ALU for the simple CPU. The controller FSM drives
// every strobe; this block returns the instruction word and Rp-zero status.
module cpu_datapath #(
   parameter int PC_W = 8,
   parameter int DW   = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            PC_clr,
   input  logic            PC_inc,
   input  logic            PC_ld,
   input  logic            I_rd,
   input  logic            IR_ld,
   output logic [PC_W-1:0] I_addr,
   input  logic [15:0]     I_rdata,
   output logic [15:0]     instruction,
   input  logic [DW-1:0]   D_rdata,
   output logic [DW-1:0]   D_wdata,
   input  logic [DW-1:0]   RF_W_data,
   input  logic            RF_s1,
   input  logic            RF_s0,
   input  logic [3:0]      RF_W_addr,
   input  logic            RF_W_wr,
   input  logic [3:0]      RF_Rp_addr,
   input  logic [3:0]      RF_Rq_addr,
   input  logic            RF_Rp_rd,
   input  logic            RF_Rq_rd,
   input  logic            alu_s1,
   input  logic            alu_s0,
   output logic            RF_Rp_zero
);

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] jump_offset;
   logic [15:0]     ir;
   logic [DW-1:0]   rf [16];
   logic [DW-1:0]   rp_data;
   logic [DW-1:0]   rq_data;
   logic [DW-1:0]   alu_result;
   logic [DW-1:0]   write_data;
   logic            write_en;

   // I_rd is an informational fetch strobe with no effect on state.
   logic unused;
   assign unused = I_rd;

   // Branch offset is the sign-extended low byte of the instruction.
   assign jump_offset = PC_W'($signed(ir[7:0]));

   // Register file read ports; a disabled port reads as zero so an
   // unqualified (possibly X) address never leaks through.
   always_comb begin
      rp_data = '0;
      rq_data = '0;
      if (RF_Rp_rd) rp_data = rf[RF_Rp_addr];
      if (RF_Rq_rd) rq_data = rf[RF_Rq_addr];
   end

   // ALU: pass, add, subtract, zero; results wrap at DW bits.
   always_comb begin
      alu_result = '0;
      case ({alu_s1, alu_s0})
         2'b00:   alu_result = rp_data;
         2'b01:   alu_result = rp_data + rq_data;
         2'b10:   alu_result = rp_data - rq_data;
         default: alu_result = '0;
      endcase
   end

   // Write-source mux; the reserved select suppresses the write entirely.
   always_comb begin
      write_data = '0;
      write_en   = 1'b0;
      if (RF_W_wr) begin
         case ({RF_s1, RF_s0})
            2'b00: begin write_data = alu_result; write_en = 1'b1; end
            2'b01: begin write_data = D_rdata;    write_en = 1'b1; end
            2'b10: begin write_data = RF_W_data;  write_en = 1'b1; end
            default: begin write_data = '0;       write_en = 1'b0; end
         endcase
      end
   end

   // Program counter: clear beats load beats increment; load undoes the
   // increment already applied during FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (PC_clr) begin
         pc <= '0;
      end else if (PC_ld) begin
         pc <= pc + jump_offset - PC_W'(1);
      end else if (PC_inc) begin
         pc <= pc + PC_W'(1);
      end
   end

   // Instruction register captures the word addressed by the current PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir <= '0;
      end else if (IR_ld) begin
         ir <= I_rdata;
      end
   end

   // Register file write port; reads in the same cycle see the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      end else if (write_en) begin
         rf[RF_W_addr] <= write_data;
      end
   end

   assign I_addr      = pc;
   assign instruction = ir;
   assign D_wdata     = rp_data;
   assign RF_Rp_zero  = RF_Rp_rd & (rp_data == '0);

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized
// cycles compared against a behavioural model of the datapath.
module tb_cpu_datapath;

   localparam int PC_W = 8;
   localparam int DW   = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            PC_clr, PC_inc, PC_ld, I_rd, IR_ld;
   logic [PC_W-1:0] I_addr;
   logic [15:0]     I_rdata;
   logic [15:0]     instruction;
   logic [DW-1:0]   D_rdata, D_wdata, RF_W_data;
   logic            RF_s1, RF_s0, RF_W_wr, RF_Rp_rd, RF_Rq_rd;
   logic [3:0]      RF_W_addr, RF_Rp_addr, RF_Rq_addr;
   logic            alu_s1, alu_s0;
   logic            RF_Rp_zero;

   int tests_run    = 0;
   int tests_failed = 0;

   // Behavioural model state.
   int         m_pc;
   logic [15:0] m_ir;
   int         m_rf [16];

   always #5 clk = ~clk;

   cpu_datapath #(.PC_W(PC_W), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .PC_clr(PC_clr), .PC_inc(PC_inc), .PC_ld(PC_ld),
      .I_rd(I_rd), .IR_ld(IR_ld), .I_addr(I_addr), .I_rdata(I_rdata),
      .instruction(instruction), .D_rdata(D_rdata), .D_wdata(D_wdata),
      .RF_W_data(RF_W_data), .RF_s1(RF_s1), .RF_s0(RF_s0),
      .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
      .RF_Rp_addr(RF_Rp_addr), .RF_Rq_addr(RF_Rq_addr),
      .RF_Rp_rd(RF_Rp_rd), .RF_Rq_rd(RF_Rq_rd),
      .alu_s1(alu_s1), .alu_s0(alu_s0), .RF_Rp_zero(RF_Rp_zero)
   );

   function automatic int sext8(input logic [7:0] v);
      return v[7] ? int'(v) - 256 : int'(v);
   endfunction

   function automatic int model_rp();
      return RF_Rp_rd ? m_rf[RF_Rp_addr] : 0;
   endfunction

   task automatic model_reset();
      m_pc = 0;
      m_ir = 16'h0000;
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
   endtask

   // Apply one rising edge's worth of architectural rules to the model.
   task automatic model_edge();
      int rp, rq, res, nxt_pc;
      rp  = RF_Rp_rd ? m_rf[RF_Rp_addr] : 0;
      rq  = RF_Rq_rd ? m_rf[RF_Rq_addr] : 0;
      res = 0;
      if (RF_W_wr) begin
         if (!alu_s1 && !alu_s0)     res = rp;
         else if (!alu_s1 && alu_s0) res = (rp + rq) & 255;
         else if (alu_s1 && !alu_s0) res = (rp - rq) & 255;
         else                        res = 0;
      end
      nxt_pc = m_pc;
      if (PC_clr)      nxt_pc = 0;
      else if (PC_ld)  nxt_pc = (m_pc + sext8(m_ir[7:0]) - 1) & 255;
      else if (PC_inc) nxt_pc = (m_pc + 1) & 255;
      if (RF_W_wr) begin
         if (!RF_s1 && !RF_s0)     m_rf[RF_W_addr] = res;
         else if (!RF_s1 && RF_s0) m_rf[RF_W_addr] = int'(D_rdata);
         else if (RF_s1 && !RF_s0) m_rf[RF_W_addr] = int'(RF_W_data);
      end
      if (IR_ld) m_ir = I_rdata;
      m_pc = nxt_pc;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      PC_clr = 0; PC_inc = 0; PC_ld = 0; I_rd = 0; IR_ld = 0;
      I_rdata = 16'h0000; D_rdata = '0; RF_W_data = '0;
      RF_s1 = 0; RF_s0 = 0; RF_W_addr = 0; RF_W_wr = 0;
      RF_Rp_addr = 0; RF_Rq_addr = 0; RF_Rp_rd = 0; RF_Rq_rd = 0;
      alu_s1 = 0; alu_s0 = 0;
   endtask

   task automatic wr_const(input logic [3:0] addr, input logic [7:0] val);
      idle();
      RF_W_addr = addr; RF_W_data = val; RF_s1 = 1; RF_s0 = 0; RF_W_wr = 1;
      tick();
      idle();
   endtask

   task automatic load_ir(input logic [15:0] word);
      idle();
      IR_ld = 1; I_rd = 1; I_rdata = word;
      tick();
      idle();
   endtask

   task automatic pc_op(input logic clr, input logic ld, input logic inc);
      idle();
      PC_clr = clr; PC_ld = ld; PC_inc = inc;
      tick();
      idle();
   endtask

   task automatic alu_op(input logic [3:0] w, input logic [3:0] p, input logic [3:0] q,
                         input logic [1:0] op);
      idle();
      RF_W_addr = w; RF_Rp_addr = p; RF_Rq_addr = q; RF_Rp_rd = 1; RF_Rq_rd = 1;
      {alu_s1, alu_s0} = op; RF_s1 = 0; RF_s0 = 0; RF_W_wr = 1;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      #12;
      @(negedge clk);
      rst_n = 1;
      model_reset();
      wr_const(4'd9, 8'h5A);
      load_ir(16'hBEEF);
      pc_op(0, 0, 1);
      pc_op(0, 0, 1);
      // Pending write to R9 when reset hits mid-cycle must be discarded.
      RF_W_addr = 9; RF_W_data = 8'h11; RF_s1 = 1; RF_s0 = 0; RF_W_wr = 1; PC_inc = 1;
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      tests_run++;
      if (I_addr !== 8'h00) begin
         tests_failed++; $display("[TB] FAIL reset_pc: got %h want 00", I_addr);
      end
      tests_run++;
      if (instruction !== 16'h0000) begin
         tests_failed++; $display("[TB] FAIL reset_ir: got %h want 0000", instruction);
      end
      tests_run++;
      if (D_wdata !== 8'h00 || RF_Rp_zero !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: D_wdata=%h zero=%b want 00/0", D_wdata, RF_Rp_zero);
      end
      @(posedge clk);
      @(negedge clk);
      idle();
      rst_n = 1;
      for (int i = 0; i < 16; i++) begin
         RF_Rp_rd = 1; RF_Rp_addr = 4'(i);
         #1;
         tests_run++;
         if (D_wdata !== 8'h00 || RF_Rp_zero !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_reg%0d: got %h zero=%b want 00/1", i, D_wdata, RF_Rp_zero);
         end
      end
      idle();
      pc_op(1, 0, 0);
      idle();
      IR_ld = 1; I_rd = 1; PC_inc = 1; I_rdata = 16'h3A05;
      tick();
      idle();
      tests_run++;
      if (instruction !== 16'h3A05 || I_addr !== 8'h01) begin
         tests_failed++;
         $display("[TB] FAIL fetch: ir=%h pc=%h want 3a05/01", instruction, I_addr);
      end
   endtask

   task automatic test_alu();
      wr_const(4'd1, 8'd5);
      wr_const(4'd2, 8'd3);
      alu_op(4'd3, 4'd1, 4'd2, 2'b01);
      alu_op(4'd4, 4'd1, 4'd2, 2'b10);
      alu_op(4'd7, 4'd2, 4'd1, 2'b10);
      alu_op(4'd8, 4'd1, 4'd2, 2'b00);
      alu_op(4'd1, 4'd1, 4'd2, 2'b11);
      RF_Rp_rd = 1;
      RF_Rp_addr = 3; #1;
      tests_run++;
      if (D_wdata !== 8'd8) begin
         tests_failed++; $display("[TB] FAIL add: R3=%h want 08", D_wdata);
      end
      RF_Rp_addr = 4; #1;
      tests_run++;
      if (D_wdata !== 8'd2) begin
         tests_failed++; $display("[TB] FAIL sub: R4=%h want 02", D_wdata);
      end
      RF_Rp_addr = 7; #1;
      tests_run++;
      if (D_wdata !== 8'hFE) begin
         tests_failed++; $display("[TB] FAIL sub_wrap: R7=%h want fe", D_wdata);
      end
      RF_Rp_addr = 8; #1;
      tests_run++;
      if (D_wdata !== 8'd5) begin
         tests_failed++; $display("[TB] FAIL pass: R8=%h want 05", D_wdata);
      end
      RF_Rp_addr = 1; #1;
      tests_run++;
      if (D_wdata !== 8'd0 || RF_Rp_zero !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL zero_op: R1=%h zero=%b want 00/1", D_wdata, RF_Rp_zero);
      end
      idle();
   endtask

   task automatic test_memory();
      idle();
      D_rdata = 8'h77; RF_s1 = 0; RF_s0 = 1; RF_W_addr = 5; RF_W_wr = 1;
      tick();
      idle();
      RF_Rp_addr = 5; RF_Rp_rd = 1;
      #1;
      tests_run++;
      if (D_wdata !== 8'h77 || RF_Rp_zero !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL load: D_wdata=%h zero=%b want 77/0", D_wdata, RF_Rp_zero);
      end
      idle();
   endtask

   task automatic test_jump();
      pc_op(1, 0, 0);
      load_ir(16'h000B);
      pc_op(0, 1, 0);
      load_ir(16'h00FC);
      wr_const(4'd6, 8'h00);
      tests_run++;
      if (I_addr !== 8'd10) begin
         tests_failed++; $display("[TB] FAIL jump_setup: pc=%h want 0a", I_addr);
      end
      RF_Rp_addr = 6; RF_Rp_rd = 1;
      #1;
      tests_run++;
      if (RF_Rp_zero !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL jz_flag: got %b want 1", RF_Rp_zero);
      end
      // Jump and register write in the same cycle.
      PC_ld = 1; RF_W_addr = 10; RF_W_data = 8'h42; RF_s1 = 1; RF_s0 = 0; RF_W_wr = 1;
      tick();
      idle();
      RF_Rp_addr = 10; RF_Rp_rd = 1;
      #1;
      tests_run++;
      if (I_addr !== 8'd5 || D_wdata !== 8'h42) begin
         tests_failed++; $display("[TB] FAIL jump_back: pc=%h R10=%h want 05/42", I_addr, D_wdata);
      end
      pc_op(1, 0, 0);
      load_ir(16'h00FF);
      pc_op(0, 1, 0);
      tests_run++;
      if (I_addr !== 8'd254) begin
         tests_failed++; $display("[TB] FAIL jump_neg: pc=%h want fe", I_addr);
      end
      load_ir(16'h0003);
      pc_op(0, 1, 0);
      tests_run++;
      if (I_addr !== 8'd0) begin
         tests_failed++; $display("[TB] FAIL jump_wrap: pc=%h want 00", I_addr);
      end
   endtask

   task automatic test_hazard();
      wr_const(4'd1, 8'd4);
      RF_W_addr = 1; RF_Rp_addr = 1; RF_Rq_addr = 1; RF_Rp_rd = 1; RF_Rq_rd = 1;
      alu_s1 = 0; alu_s0 = 1; RF_s1 = 0; RF_s0 = 0; RF_W_wr = 1;
      #1;
      tests_run++;
      if (D_wdata !== 8'd4) begin
         tests_failed++; $display("[TB] FAIL hazard_old: got %h want 04", D_wdata);
      end
      tick();
      RF_W_wr = 0;
      #1;
      tests_run++;
      if (D_wdata !== 8'd8) begin
         tests_failed++; $display("[TB] FAIL hazard_new: got %h want 08", D_wdata);
      end
      wr_const(4'd11, 8'h33);
      RF_W_addr = 11; RF_W_data = 8'h99; RF_s1 = 1; RF_s0 = 1; RF_W_wr = 1;
      tick();
      idle();
      RF_Rp_addr = 11; RF_Rp_rd = 1;
      #1;
      tests_run++;
      if (D_wdata !== 8'h33) begin
         tests_failed++; $display("[TB] FAIL reserved_sel: R11=%h want 33", D_wdata);
      end
      idle();
   endtask

   task automatic test_x_tolerance();
      idle();
      I_rdata = 'x; D_rdata = 'x; RF_W_data = 'x; RF_s1 = 'x; RF_s0 = 'x;
      RF_W_addr = 'x; RF_Rp_addr = 'x; RF_Rq_addr = 'x; alu_s1 = 'x; alu_s0 = 'x;
      I_rd = 'x;
      for (int c = 0; c < 10; c++) tick();
      tests_run++;
      if (D_wdata !== 8'h00 || RF_Rp_zero !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL x_outputs: D_wdata=%h zero=%b want 00/0", D_wdata, RF_Rp_zero);
      end
      idle();
      #1;
      tests_run++;
      if (I_addr !== 8'(m_pc) || instruction !== m_ir) begin
         tests_failed++;
         $display("[TB] FAIL x_state: pc=%h ir=%h want %h/%h", I_addr, instruction, 8'(m_pc), m_ir);
      end
      for (int i = 0; i < 16; i++) begin
         RF_Rp_rd = 1; RF_Rp_addr = 4'(i);
         #1;
         tests_run++;
         if (D_wdata !== 8'(m_rf[i])) begin
            tests_failed++; $display("[TB] FAIL x_reg%0d: got %h want %h", i, D_wdata, 8'(m_rf[i]));
         end
      end
      idle();
   endtask

   task automatic test_priority();
      pc_op(1, 0, 0);
      load_ir(16'h0005);
      pc_op(0, 0, 1);
      pc_op(0, 0, 1);
      pc_op(0, 0, 1);
      pc_op(0, 1, 1);
      tests_run++;
      if (I_addr !== 8'd7) begin
         tests_failed++; $display("[TB] FAIL ld_over_inc: pc=%h want 07", I_addr);
      end
      pc_op(1, 1, 1);
      tests_run++;
      if (I_addr !== 8'd0) begin
         tests_failed++; $display("[TB] FAIL clr_priority: pc=%h want 00", I_addr);
      end
   endtask

   task automatic test_random();
      int n_fail_prints = 0;
      for (int c = 0; c < 400; c++) begin
         idle();
         RF_Rp_addr = 4'($urandom); RF_Rq_addr = 4'($urandom);
         RF_Rp_rd = 1'($urandom_range(0, 3) != 0); RF_Rq_rd = 1'($urandom);
         {alu_s1, alu_s0} = 2'($urandom); {RF_s1, RF_s0} = 2'($urandom);
         RF_W_addr = 4'($urandom); RF_W_wr = 1'($urandom);
         RF_W_data = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
         D_rdata = 8'($urandom);
         I_rdata = 16'($urandom); IR_ld = 1'($urandom); I_rd = IR_ld;
         PC_clr = ($urandom_range(0, 15) == 0); PC_ld = ($urandom_range(0, 3) == 0);
         PC_inc = 1'($urandom);
         #1;
         tests_run++;
         if (D_wdata !== 8'(model_rp()) || RF_Rp_zero !== (RF_Rp_rd && model_rp() == 0) ||
             I_addr !== 8'(m_pc) || instruction !== m_ir) begin
            tests_failed++;
            if (n_fail_prints < 20) begin
               n_fail_prints++;
               $display("[TB] FAIL random_cycle%0d: D_wdata=%h zero=%b pc=%h ir=%h want %h/%b/%h/%h",
                        c, D_wdata, RF_Rp_zero, I_addr, instruction, 8'(model_rp()),
                        RF_Rp_rd && model_rp() == 0, 8'(m_pc), m_ir);
            end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_memory();
      test_jump();
      test_hazard();
      test_x_tolerance();
      test_priority();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
